// File: rtl/ctrl_pkg.sv
// Shared types and constants for the 16-bit CPU instruction sequencer.
package ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_SHL  = 4'h6,
    OP_SHR  = 4'h7,
    OP_LDI  = 4'h8,
    OP_ADDI = 4'h9,
    OP_HALT = 4'hF
  } opcode_e;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_READ   = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;
  localparam logic [2:0] ST_HALTED = 3'd5;

  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 8;
  localparam int RA_LSB  = 4;
  localparam int RB_LSB  = 0;

  localparam logic [3:0] ALU_ADD    = 4'h1;
  localparam logic [3:0] ALU_PASS_B = 4'hF;

  // Fields the execute phases need; kept apart from the class flags the FSM consumes.
  typedef struct packed {
    logic [3:0]  rd;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [15:0] imm;
    logic [3:0]  alu_op;
    logic        is_rtype;
    logic        is_imm;
    logic        is_ldi;
  } op_t;

  typedef struct packed {
    op_t  op;
    logic is_nop;
    logic is_halt;
    logic is_illegal;
  } dec_t;

  typedef struct packed {
    logic        instr_ready;
    logic [4:0]  addr_a;
    logic [4:0]  addr_b;
    logic [4:0]  addr_d;
    logic        re_a;
    logic        re_b;
    logic        we_d;
    logic [3:0]  alu_op;
    logic [15:0] imm;
    logic        imm_oe;
    logic        halted;
    logic        illegal;
  } ctrl_out_t;

  function automatic ctrl_out_t out_reset();
    ctrl_out_t o;
    o = '0;
    o.instr_ready = 1'b1;
    return o;
  endfunction

endpackage

// File: rtl/ctrl_sequencer_instr_decode.sv
// Combinational instruction field extraction and opcode classification.
import ctrl_pkg::*;

module instr_decode (
  input  logic [15:0] instr,
  output dec_t        dec
);

  logic [3:0] opc;
  assign opc = instr[OPC_LSB +: 4];

  always_comb begin
    dec           = '0;
    dec.op.rd     = instr[RD_LSB +: 4];
    dec.op.ra     = instr[RA_LSB +: 4];
    dec.op.rb     = instr[RB_LSB +: 4];
    case (opc)
      OP_NOP: dec.is_nop = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
        dec.op.is_rtype = 1'b1;
        dec.op.alu_op   = opc;
      end
      OP_LDI: begin
        dec.op.is_imm = 1'b1;
        dec.op.is_ldi = 1'b1;
        dec.op.imm    = {8'h00, instr[7:0]};
        dec.op.alu_op = ALU_PASS_B;
      end
      OP_ADDI: begin
        dec.op.is_imm = 1'b1;
        dec.op.imm    = {12'h000, instr[3:0]};
        dec.op.alu_op = ALU_ADD;
      end
      OP_HALT: dec.is_halt = 1'b1;
      default: dec.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle IDLE/DECODE/READ/EXEC/WRITE sequencer driving the register file and ALU.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (opcodes A-E trap into HALTED with illegal=1).
import ctrl_pkg::*;

module ctrl_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [4:0]  regAddrA,
  output logic [4:0]  regAddrB,
  output logic [4:0]  regAddrD,
  output logic        regReA,
  output logic        regReB,
  output logic        regWeD,
  output logic [3:0]  alu_op,
  output logic [15:0] imm,
  output logic        imm_oe,
  output logic        halted,
  output logic        illegal,
  output logic [2:0]  dbg_state
);

  // Handshake: instr is taken on a rising edge where instr_valid and instr_ready are both
  // high; the producer holds instr stable until then, and valid while not ready is ignored.

  logic [2:0]  state_q, state_d;
  logic [15:0] instr_q, instr_d;
  op_t         op_q, op_d;
  logic        trap_q, trap_d;
  ctrl_out_t   outs_q, outs_d;
  dec_t        dec_w;
  logic        active;

  instr_decode u_decode (
    .instr (instr_q),
    .dec   (dec_w)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    op_d    = op_q;
    trap_d  = trap_q;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid && outs_q.instr_ready) begin
          instr_d = instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        op_d = dec_w.op;
        if (dec_w.is_halt) begin
          state_d = ST_HALTED;
        end else if (dec_w.is_illegal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          trap_d  = 1'b1;
          state_d = ST_HALTED;
`else
          state_d = ST_IDLE;
`endif
        end else if (dec_w.is_nop) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_READ:   state_d = ST_EXEC;
      ST_EXEC:   state_d = ST_WRITE;
      ST_WRITE:  state_d = ST_IDLE;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the current state, so they trail it by one cycle;
  // instr_ready looks at the next state so an idle sequencer accepts without a bubble.
  always_comb begin
    active             = (state_q == ST_READ) || (state_q == ST_EXEC) || (state_q == ST_WRITE);
    outs_d             = '0;
    outs_d.instr_ready = (state_d == ST_IDLE);
    if (active) begin
      outs_d.addr_a = {1'b0, op_q.ra};
      outs_d.re_a   = !op_q.is_ldi;
      if (op_q.is_rtype) begin
        outs_d.addr_b = {1'b0, op_q.rb};
        outs_d.re_b   = 1'b1;
      end
      outs_d.imm_oe = op_q.is_imm;
      outs_d.imm    = op_q.imm;
      outs_d.alu_op = op_q.alu_op;
      outs_d.addr_d = {1'b0, op_q.rd};
      outs_d.we_d   = (state_q == ST_WRITE);
    end
    outs_d.halted  = (state_q == ST_HALTED);
    outs_d.illegal = (state_q == ST_HALTED) && trap_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      op_q    <= '0;
      trap_q  <= 1'b0;
      outs_q  <= out_reset();
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      op_q    <= op_d;
      trap_q  <= trap_d;
      outs_q  <= outs_d;
    end
  end

  assign instr_ready = outs_q.instr_ready;
  assign regAddrA    = outs_q.addr_a;
  assign regAddrB    = outs_q.addr_b;
  assign regAddrD    = outs_q.addr_d;
  assign regReA      = outs_q.re_a;
  assign regReB      = outs_q.re_b;
  assign regWeD      = outs_q.we_d;
  assign alu_op      = outs_q.alu_op;
  assign imm         = outs_q.imm;
  assign imm_oe      = outs_q.imm_oe;
  assign halted      = outs_q.halted;
  assign illegal     = outs_q.illegal;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed self-checking bench for ctrl_sequencer with a register-write scoreboard.
module tb_ctrl_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [4:0]  regAddrA, regAddrB, regAddrD;
  logic        regReA, regReB, regWeD;
  logic [3:0]  alu_op;
  logic [15:0] imm;
  logic        imm_oe, halted, illegal;
  logic [2:0]  dbg_state;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          we_pulses = 0;
  logic        we_prev = 1'b0;
  logic [4:0]  exp_q[$];
  int          acc_log[$];

  ctrl_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .regAddrA    (regAddrA),
    .regAddrB    (regAddrB),
    .regAddrD    (regAddrD),
    .regReA      (regReA),
    .regReB      (regReB),
    .regWeD      (regWeD),
    .alu_op      (alu_op),
    .imm         (imm),
    .imm_oe      (imm_oe),
    .halted      (halted),
    .illegal     (illegal),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // accept log: handshake seen at the edge
  always @(posedge clk) begin
    cyc++;
    if (instr_valid && instr_ready) acc_log.push_back(cyc);
  end

  // scoreboard: every write strobe rising edge must match the next expected rd
  always @(negedge clk) begin
    if (regWeD && !we_prev) begin
      we_pulses++;
      if (exp_q.size() == 0) check("wr_unexpected", exp_q.size(), 1);
      else check("wr_addr", regAddrD, exp_q.pop_front());
    end
    if (regWeD && we_prev) check("we_width", we_prev, 0);
    we_prev = regWeD;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w);
    int n;
    instr = w;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("ready_timeout", instr_ready, 1);
    tick();
    instr_valid = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", instr_ready, 1);
    check("rst_we", regWeD, 0);
    check("rst_reA", regReA, 0);
    check("rst_reB", regReB, 0);
    check("rst_halted", halted, 0);
    check("rst_alu", alu_op, 0);
    check("rst_imm", imm, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    tick();

    // ADD r1 <= r2 + r3
    exp_q.push_back(5'd1);
    send(16'h1123);
    check("add_ready_low", instr_ready, 0);
    tick(); tick();
    check("add_addrA", regAddrA, 2);
    check("add_addrB", regAddrB, 3);
    check("add_reA", regReA, 1);
    check("add_reB", regReB, 1);
    check("add_alu", alu_op, 1);
    check("add_addrD", regAddrD, 1);
    check("add_we_early", regWeD, 0);
    check("add_imm_oe", imm_oe, 0);
    tick(); tick();
    check("add_we", regWeD, 1);
    check("add_addrA_hold", regAddrA, 2);
    check("add_ready_back", instr_ready, 1);
    tick();
    check("add_we_off", regWeD, 0);

    // LDI r5 <= 0x00A5
    exp_q.push_back(5'd5);
    send(16'h85A5);
    tick(); tick();
    check("ldi_reA", regReA, 0);
    check("ldi_reB", regReB, 0);
    check("ldi_imm_oe", imm_oe, 1);
    check("ldi_imm", imm, 16'h00A5);
    check("ldi_alu", alu_op, 4'hF);
    check("ldi_addrD", regAddrD, 5);
    tick(); tick();
    check("ldi_we", regWeD, 1);
    tick();

    // back-to-back ADDI r4 <= r1 + 7 with valid held
    exp_q.push_back(5'd4);
    exp_q.push_back(5'd4);
    instr = 16'h9417;
    instr_valid = 1'b1;
    tick();
    tick(); tick();
    check("addi_imm", imm, 16'h0007);
    check("addi_addrA", regAddrA, 1);
    check("addi_alu", alu_op, 1);
    check("addi_imm_oe", imm_oe, 1);
    check("addi_reA", regReA, 1);
    check("addi_reB", regReB, 0);
    tick(); tick(); tick();
    instr_valid = 1'b0;
    n = acc_log.size();
    if (n >= 2) check("b2b_gap", acc_log[n-1] - acc_log[n-2], 5);
    else check("b2b_accepts", n, 2);
    repeat (6) tick();

    // NOP: two-cycle turnaround, no enables
    send(16'h0000);
    check("nop_ready_low", instr_ready, 0);
    tick();
    check("nop_ready_back", instr_ready, 1);
    check("nop_reA", regReA, 0);
    check("nop_we", regWeD, 0);
    tick();

    // illegal opcode
    send(16'hB000);
    tick();
`ifdef CTRL_ILLEGAL_TRAP_EN
    check("ill_ready", instr_ready, 0);
    tick();
    check("ill_flag", illegal, 1);
    check("ill_halted", halted, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
`else
    check("ill_ready", instr_ready, 1);
    check("ill_flag", illegal, 0);
    check("ill_halted", halted, 0);
    tick();
`endif

    // reset during EXEC of SUB r3 <= r4 - r5
    send(16'h2345);
    tick(); tick();
    check("sub_reA", regReA, 1);
    rst_n = 1'b0;
    #1;
    check("abort_we", regWeD, 0);
    check("abort_reA", regReA, 0);
    check("abort_ready", instr_ready, 1);
    check("abort_addrA", regAddrA, 0);
    check("abort_alu", alu_op, 0);
    check("abort_state", dbg_state, 0);
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.push_back(5'd1);
    send(16'h1123);
    tick(); tick();
    check("post_rst_addrA", regAddrA, 2);
    check("post_rst_addrB", regAddrB, 3);
    repeat (4) tick();

    // HALT, then valid must be ignored
    send(16'hF000);
    tick(); tick();
    check("halt_halted", halted, 1);
    check("halt_ready", instr_ready, 0);
    check("halt_illegal", illegal, 0);
    check("halt_reA", regReA, 0);
    n = acc_log.size();
    instr = 16'h1123;
    instr_valid = 1'b1;
    repeat (5) tick();
    check("halt_no_accept", acc_log.size(), n);
    check("halt_ready_hold", instr_ready, 0);
    check("halt_we", regWeD, 0);
    check("halt_state", dbg_state, 5);
    instr_valid = 1'b0;

    // final report
    check("wr_pending", exp_q.size(), 0);
    check("we_pulses", we_pulses, 5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
